// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  typedef logic [3:0] kp_code_t;

  typedef enum logic [1:0] {
    KP_SCAN,
    KP_DEBOUNCE,
    KP_PRESSED
  } kp_state_t;

endpackage

// File: rtl/keypad_row_driver.sv
// Rotating one-hot-low row strobe: holds each row for SCAN_TICKS cycles and
// flags the sample point of every row and the end of each full scan.
module keypad_row_driver #(
  parameter int SCAN_TICKS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row_n_o,
  output logic [1:0] row_idx_o,
  output logic       sample_en_o,
  output logic       scan_done_o
);

  localparam int TW = $clog2(SCAN_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    row_q, row_d;

  always_comb begin
    sample_en_o = (tick_q == TICK_LAST);
    scan_done_o = sample_en_o && (row_q == 2'd3);
    tick_d      = sample_en_o ? '0 : tick_q + 1'b1;
    row_d       = sample_en_o ? row_q + 2'd1 : row_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly as the hardware does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      row_q  <= '0;
    end else begin
      tick_q <= tick_d;
      row_q  <= row_d;
    end
  end

  assign row_n_o   = ~(4'b0001 << row_q);
  assign row_idx_o = row_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with whole-scan debounce and one-cycle key strobe.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output kp_code_t key_code,
  output logic     key_valid,
  output logic     key_pressed
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_SCANS);

  logic [1:0] row_idx;
  logic       sample_en, scan_done;

  keypad_row_driver #(.SCAN_TICKS(SCAN_TICKS)) u_row_driver (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_n_o     (row_n),
    .row_idx_o   (row_idx),
    .sample_en_o (sample_en),
    .scan_done_o (scan_done)
  );

  // Columns idle high, so the synchroniser resets to "nothing pressed".
  logic [3:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= col_n;
      sync2_q <= sync1_q;
    end
  end

  // Candidate encoder: the first hit of a scan (lowest row, then lowest column) wins.
  logic     row_found, cand_found, scan_found_q;
  logic [1:0] row_col;
  kp_code_t cand_code, scan_code_q;

  always_comb begin
    row_found = |(~sync2_q);
    row_col   = '0;
    for (int c = KP_COLS - 1; c >= 0; c--) begin
      if (!sync2_q[c]) row_col = 2'(c);
    end
    if (row_idx != 2'd0 && scan_found_q) begin
      cand_found = 1'b1;
      cand_code  = scan_code_q;
    end else begin
      cand_found = row_found;
      cand_code  = {row_idx, row_col};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_found_q <= 1'b0;
      scan_code_q  <= '0;
    end else if (sample_en) begin
      scan_found_q <= cand_found;
      scan_code_q  <= cand_code;
    end
  end

  kp_state_t     state_q, state_d;
  kp_code_t      key_q, key_d, code_q, code_d;
  logic [CW-1:0] agree_q, agree_d, rel_q, rel_d;
  logic          valid_q, valid_d, accept;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_SCANS);
  logic [RW-1:0] rep_q, rep_d;
`else
  localparam int unused_repeat_scans = REPEAT_SCANS;
`endif

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    code_d  = code_q;
    agree_d = agree_q;
    rel_d   = rel_q;
    valid_d = 1'b0;
    accept  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif
    if (scan_done) begin
      case (state_q)
        KP_SCAN: begin
          if (cand_found) begin
            key_d   = cand_code;
            agree_d = CW'(1);
            if (DEBOUNCE_SCANS == 1) accept = 1'b1;
            else                     state_d = KP_DEBOUNCE;
          end
        end
        KP_DEBOUNCE: begin
          if (cand_found && cand_code == key_q) begin
            agree_d = agree_q + 1'b1;
            if (agree_d == DB_LAST) accept = 1'b1;
          end else begin
            state_d = KP_SCAN;
            agree_d = '0;
          end
        end
        KP_PRESSED: begin
          if (!cand_found) begin
            rel_d = rel_q + 1'b1;
            if (rel_d == DB_LAST) begin
              state_d = KP_SCAN;
              rel_d   = '0;
            end
          end else begin
            rel_d = '0;
          end
`ifdef KEYPAD_REPEAT_EN
          if (!cand_found) begin
            rep_d = '0;
          end else if (cand_code == key_q) begin
            rep_d = rep_q + 1'b1;
            if (rep_d == RP_LAST) begin
              valid_d = 1'b1;
              rep_d   = '0;
            end
          end
`endif
        end
        default: state_d = KP_SCAN;
      endcase

      if (accept) begin
        state_d = KP_PRESSED;
        code_d  = key_d;
        valid_d = 1'b1;
        agree_d = '0;
        rel_d   = '0;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= KP_SCAN;
      key_q   <= '0;
      code_q  <= '0;
      agree_q <= '0;
      rel_q   <= '0;
      valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      code_q  <= code_d;
      agree_q <= agree_d;
      rel_q   <= rel_d;
      valid_q <= valid_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_pressed = (state_q == KP_PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: SCAN_TICKS=4, DEBOUNCE_SCANS=2 (16-cycle scans).
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int ST = 4;
  localparam int DS = 2;
  localparam int RS = 3;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP = 1;
`else
  localparam int REP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  kp_code_t   key_code;
  logic       key_valid;
  logic       key_pressed;
  logic [15:0] keys = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nvalid = 0;
  int first_v = -1;
  int last_v = -1;
  int s = 0;
  bit chk_rows = 1'b0;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
  } vec_t;
  vec_t vecs[8];

  keypad_scanner #(
    .SCAN_TICKS     (ST),
    .DEBOUNCE_SCANS (DS),
    .REPEAT_SCANS   (RS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .col_n       (col_n),
    .row_n       (row_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_pressed (key_pressed)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed switch shorts its column to its row when that row is driven low.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  function automatic logic [15:0] k(input int r, input int c);
    logic [15:0] m;
    m = 16'd1;
    return m << (r*4 + c);
  endfunction

  function automatic logic [3:0] exp_row(input int c);
    logic [3:0] r;
    r = 4'b1111;
    r[(c/4) % 4] = 1'b0;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clr_mon();
    nvalid = 0;
    first_v = -1;
    last_v = -1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (key_valid === 1'b1) begin
        nvalid++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (chk_rows) check("row_n", {28'd0, row_n}, {28'd0, exp_row(cyc)});
    end
  endtask

  initial begin
    vecs[0] = '{k(0,0),            4'd0};
    vecs[1] = '{k(2,1),            4'd9};
    vecs[2] = '{k(1,3),            4'd7};
    vecs[3] = '{k(3,0),            4'd12};
    vecs[4] = '{k(3,3),            4'd15};
    vecs[5] = '{k(1,1) | k(2,0),   4'd5};
    vecs[6] = '{k(2,3) | k(2,1),   4'd9};
    vecs[7] = '{k(0,3) | k(3,0),   4'd3};

    // Reset state, released midway through a low clock phase.
    #2 rst_n = 1'b0;
    #1;
    check("rst_row_n", {28'd0, row_n}, 32'd14);
    check("rst_code", {28'd0, key_code}, 32'd0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_pressed", {31'd0, key_pressed}, 32'd0);
    #9 rst_n = 1'b1;
    cyc = 0;

    // Idle: row strobe rotation, no strobes.
    chk_rows = 1'b1;
    clr_mon();
    run(64);
    chk_rows = 1'b0;
    check("idle_valid_cnt", nvalid, 0);
    check("idle_pressed", {31'd0, key_pressed}, 32'd0);

    // Table of single presses and simultaneous-key priority cases.
    foreach (vecs[i]) begin
      s = cyc;
      keys = vecs[i].keys;
      clr_mon();
      run(48);
      check($sformatf("vec%0d_valid_cnt", i), nvalid, 1);
      check($sformatf("vec%0d_latency", i), first_v - s, 32);
      check($sformatf("vec%0d_code", i), {28'd0, key_code}, {28'd0, vecs[i].code});
      check($sformatf("vec%0d_pressed", i), {31'd0, key_pressed}, 32'd1);
      keys = '0;
      clr_mon();
      run(32);
      check($sformatf("vec%0d_released", i), {31'd0, key_pressed}, 32'd0);
      check($sformatf("vec%0d_no_strobe", i), nvalid, 0);
      check($sformatf("vec%0d_code_held", i), {28'd0, key_code}, {28'd0, vecs[i].code});
    end

    // (2,1) held 4 scans; release takes exactly 2 scans.
    s = cyc;
    keys = k(2,1);
    clr_mon();
    run(64);
    check("k21_valid_cnt", nvalid, 1);
    check("k21_latency", first_v - s, 32);
    check("k21_code", {28'd0, key_code}, 32'd9);
    keys = '0;
    run(31);
    check("k21_pressed_before_rel", {31'd0, key_pressed}, 32'd1);
    run(1);
    check("k21_pressed_after_rel", {31'd0, key_pressed}, 32'd0);
    check("k21_single_strobe", nvalid, 1);

    // (0,3) for one scan only: no strobe, and the FSM is back in SCAN.
    keys = k(0,3);
    clr_mon();
    run(16);
    keys = '0;
    run(16);
    check("short_valid_cnt", nvalid, 0);
    check("short_pressed", {31'd0, key_pressed}, 32'd0);
    s = cyc;
    keys = k(1,1);
    clr_mon();
    run(48);
    check("after_short_latency", first_v - s, 32);
    check("after_short_code", {28'd0, key_code}, 32'd5);
    keys = '0;
    run(32);

    // Hold (1,0), add (3,3), then swap: only one report until a fresh press.
    s = cyc;
    keys = k(1,0);
    clr_mon();
    run(48);
    check("hold_latency", first_v - s, 32);
    check("hold_code", {28'd0, key_code}, 32'd4);
    keys = keys | k(3,3);
    clr_mon();
    run(48);
    check("hold_add_valid_cnt", nvalid, REP);
    check("hold_add_code", {28'd0, key_code}, 32'd4);
    keys = k(3,3);
    clr_mon();
    run(64);
    check("hold_swap_valid_cnt", nvalid, 0);
    check("hold_swap_code", {28'd0, key_code}, 32'd4);
    check("hold_swap_pressed", {31'd0, key_pressed}, 32'd1);
    keys = '0;
    run(32);
    check("hold_swap_released", {31'd0, key_pressed}, 32'd0);
    s = cyc;
    keys = k(3,3);
    clr_mon();
    run(48);
    check("repress_valid_cnt", nvalid, 1);
    check("repress_latency", first_v - s, 32);
    check("repress_code", {28'd0, key_code}, 32'd15);
    keys = '0;
    run(32);

    // Reset mid-debounce of (3,2): outputs clear at once, debounce restarts.
    keys = k(3,2);
    clr_mon();
    run(20);
    rst_n = 1'b0;
    #1;
    check("midrst_row_n", {28'd0, row_n}, 32'd14);
    check("midrst_code", {28'd0, key_code}, 32'd0);
    check("midrst_valid", {31'd0, key_valid}, 32'd0);
    check("midrst_pressed", {31'd0, key_pressed}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc = 0;
    clr_mon();
    run(48);
    check("midrst_valid_cnt", nvalid, 1);
    check("midrst_latency", first_v, 32);
    check("midrst_new_code", {28'd0, key_code}, 32'd14);
    keys = '0;
    run(32);
    check("midrst_released", {31'd0, key_pressed}, 32'd0);

`ifdef KEYPAD_REPEAT_EN
    // (1,2) held 10 scans: initial strobe then one every 3 scans.
    s = cyc;
    keys = k(1,2);
    clr_mon();
    run(160);
    check("rep_valid_cnt", nvalid, 3);
    check("rep_first", first_v - s, 32);
    check("rep_last", last_v - s, 128);
    check("rep_code", {28'd0, key_code}, 32'd6);
    keys = '0;
    run(32);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
